// File: rtl/bar_field.sv
// -----------------------------------------------------------------------------
// bar_field
//   Obstacle bar playfield. Holds NUM_BARS bars, each with a top-of-opening
//   position, an opening height and a signed vertical speed. A level load
//   walks through the bars one per cycle and fills them from one of two fixed
//   tables. The table is chosen by the parity of `level`. Once all bars are
//   loaded, every `step` tick moves all bars together. Bars either wrap
//   around the screen or bounce off its edges, depending on WRAP_MODE.
//
// Parameters
//   NUM_BARS  number of bars (2..16)
//   POS_W     width of position / opening values
//   SPD_W     width of the signed per-bar speed
//   SCREEN_H  playfield height in pixels
//   WRAP_MODE 1 = wrap at the screen edges, 0 = bounce
//
// Ports
//   clkenv      in   environment clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pause       in   freezes bar movement while high
//   step        in   one-cycle movement tick
//   level_load  in   one-cycle request to (re)load the bars
//   level       in   level number; odd -> table A, even -> table B
//   bar_pos     out  packed positions, bar i at [i*POS_W +: POS_W]
//   bar_op      out  packed opening heights, same packing
//   bars_valid  out  every bar holds loaded data
//   busy        out  a load is in progress
// -----------------------------------------------------------------------------
module bar_field #(
  parameter int NUM_BARS  = 8,
  parameter int POS_W     = 10,
  parameter int SPD_W     = 6,
  parameter int SCREEN_H  = 480,
  parameter int WRAP_MODE = 1
) (
  input  logic                      clkenv,
  input  logic                      rst_n,
  input  logic                      pause,
  input  logic                      step,
  input  logic                      level_load,
  input  logic [POS_W-1:0]          level,
  output logic [NUM_BARS*POS_W-1:0] bar_pos,
  output logic [NUM_BARS*POS_W-1:0] bar_op,
  output logic                      bars_valid,
  output logic                      busy
);

  localparam int CNT_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  // Two guard bits give room for the sign and for pos + speed overflow.
  localparam int EXT_W = POS_W + 2;
  // One more bit so that n + op can never overflow.
  localparam int SUM_W = POS_W + 3;

  localparam logic signed [EXT_W-1:0] SCREEN_X = EXT_W'(SCREEN_H);
  localparam logic signed [SUM_W-1:0] SCREEN_S = SUM_W'(SCREEN_H);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BARS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Level tables
  // ---------------------------------------------------------------------------

  // Start position is the same in both tables: even bars mid-screen, odd bars higher.
  function automatic logic [POS_W-1:0] tbl_pos(input logic [CNT_W-1:0] idx);
    logic [POS_W-1:0] v;
    if ((32'(idx) % 32'd2) == 32'd0) begin
      v = POS_W'(32'd240);
    end else begin
      v = POS_W'(32'd120);
    end
    return v;
  endfunction

  // Table A has a fixed opening. Table B's opening grows with the bar index mod 4.
  function automatic logic [POS_W-1:0] tbl_op(input logic tab_a,
                                               input logic [CNT_W-1:0] idx);
    logic [POS_W-1:0] v;
    if (tab_a) begin
      v = POS_W'(32'd60);
    end else begin
      v = POS_W'(32'd60 + 32'd10 * (32'(idx) % 32'd4));
    end
    return v;
  endfunction

  // Even bars move up and odd bars move down. Table B is faster.
  function automatic logic signed [SPD_W-1:0] tbl_spd(input logic tab_a,
                                                      input logic [CNT_W-1:0] idx);
    logic signed [SPD_W-1:0] v;
    logic                    even;
    even = ((32'(idx) % 32'd2) == 32'd0);
    if (tab_a) begin
      if (even) begin
        v = SPD_W'(-32'sd10);
      end else begin
        v = SPD_W'(32'sd10);
      end
    end else begin
      if (even) begin
        v = SPD_W'(-32'sd20);
      end else begin
        v = SPD_W'(32'sd15);
      end
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    tab_a_r;
  logic [POS_W-1:0]        pos_r [NUM_BARS];
  logic [POS_W-1:0]        op_r  [NUM_BARS];
  logic signed [SPD_W-1:0] spd_r [NUM_BARS];
  logic                    valid_r;
  logic                    busy_r;

  logic [POS_W-1:0]        pos_nxt_s [NUM_BARS];
  logic signed [SPD_W-1:0] spd_nxt_s [NUM_BARS];
  logic signed [EXT_W-1:0] n_s       [NUM_BARS];
  logic signed [EXT_W-1:0] lim_s     [NUM_BARS];
  logic signed [SUM_W-1:0] top_s     [NUM_BARS];
  logic                    move_s;

  // Only the parity of level selects a table. The upper bits are
  // intentionally unused.
  logic level_unused_s;
  assign level_unused_s = ^level[POS_W-1:1];

  // A load request in the same cycle as a step wins, so it suppresses movement.
  assign move_s = (state_r == ST_RUN) && step && !pause && !level_load;

  // Next position and speed of every bar for one movement tick.
  always_comb begin
    for (int i = 0; i < NUM_BARS; i++) begin
      n_s[i]   = $signed({2'b00, pos_r[i]})
               + $signed({{(EXT_W-SPD_W){spd_r[i][SPD_W-1]}}, spd_r[i]});
      lim_s[i] = SCREEN_X - $signed({2'b00, op_r[i]});
      top_s[i] = $signed({n_s[i][EXT_W-1], n_s[i]}) + $signed({3'b000, op_r[i]});
      pos_nxt_s[i] = pos_r[i];
      spd_nxt_s[i] = spd_r[i];
      if (WRAP_MODE != 0) begin
        // Leaving the top re-enters at the bottom, and the reverse.
        if (n_s[i][EXT_W-1] == 1'b1) begin
          pos_nxt_s[i] = lim_s[i][POS_W-1:0];
        end else if (n_s[i] > lim_s[i]) begin
          pos_nxt_s[i] = '0;
        end else begin
          pos_nxt_s[i] = n_s[i][POS_W-1:0];
        end
      end else begin
        // Clamp to the edge that was crossed and reverse direction.
        if (n_s[i][EXT_W-1] == 1'b1) begin
          pos_nxt_s[i] = '0;
          spd_nxt_s[i] = -spd_r[i];
        end else if (top_s[i] > SCREEN_S) begin
          pos_nxt_s[i] = lim_s[i][POS_W-1:0];
          spd_nxt_s[i] = -spd_r[i];
        end else begin
          pos_nxt_s[i] = n_s[i][POS_W-1:0];
        end
      end
    end
  end

  // Control FSM and bar storage: load sequencing, movement, async clear.
  always_ff @(posedge clkenv or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      tab_a_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        pos_r[i] <= '0;
        op_r[i]  <= '0;
        spd_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_load) begin
            state_r <= ST_LOAD;
            cnt_r   <= '0;
            tab_a_r <= level[0];
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // New level_load requests are ignored here. Bars above cnt_r keep
          // their old contents until they are rewritten.
          pos_r[cnt_r] <= tbl_pos(cnt_r);
          op_r[cnt_r]  <= tbl_op(tab_a_r, cnt_r);
          spd_r[cnt_r] <= tbl_spd(tab_a_r, cnt_r);
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (level_load) begin
            state_r <= ST_LOAD;
            cnt_r   <= '0;
            tab_a_r <= level[0];
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
          end else if (move_s) begin
            for (int i = 0; i < NUM_BARS; i++) begin
              pos_r[i] <= pos_nxt_s[i];
              spd_r[i] <= spd_nxt_s[i];
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are plain wiring from the bar registers.
  for (genvar g = 0; g < NUM_BARS; g++) begin : g_pack
    assign bar_pos[g*POS_W +: POS_W] = pos_r[g];
    assign bar_op[g*POS_W +: POS_W]  = op_r[g];
  end

  assign bars_valid = valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_bar_field.sv
module tb_bar_field;

  localparam int N  = 8;
  localparam int PW = 10;
  localparam int SH = 480;
  localparam int W  = N * PW;

  logic          clkenv = 1'b0;
  logic          rst_n = 1'b0;
  logic          pause = 1'b0;
  logic          step = 1'b0;
  logic          level_load = 1'b0;
  logic [PW-1:0] level = '0;

  logic [W-1:0]  pos_w, op_w, pos_b, op_b;
  logic          valid_w, busy_w, valid_b, busy_b;

  always #5 clkenv = ~clkenv;

  bar_field #(.NUM_BARS(N), .POS_W(PW), .SPD_W(6), .SCREEN_H(SH), .WRAP_MODE(1)) dut_w (
    .clkenv(clkenv), .rst_n(rst_n), .pause(pause), .step(step),
    .level_load(level_load), .level(level),
    .bar_pos(pos_w), .bar_op(op_w), .bars_valid(valid_w), .busy(busy_w)
  );

  bar_field #(.NUM_BARS(N), .POS_W(PW), .SPD_W(6), .SCREEN_H(SH), .WRAP_MODE(0)) dut_b (
    .clkenv(clkenv), .rst_n(rst_n), .pause(pause), .step(step),
    .level_load(level_load), .level(level),
    .bar_pos(pos_b), .bar_op(op_b), .bars_valid(valid_b), .busy(busy_b)
  );

  typedef struct {
    logic [W-1:0] pos_w;
    logic [W-1:0] op_w;
    logic [W-1:0] pos_b;
    logic [W-1:0] op_b;
    logic         valid;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fails  = 0;

  // Reference model: index 0 = wrapping field, index 1 = bouncing field
  int m_pos [2][N];
  int m_op  [2][N];
  int m_spd [2][N];
  int m_phase = 0;   // 0 idle, 1 loading, 2 running
  int m_idx   = 0;
  bit m_tab_a = 1'b0;
  bit m_valid = 1'b0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic logic [W-1:0] bar(logic [W-1:0] v, int i);
    return W'(v[i*PW +: PW]);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_pos[d][i] = 0; m_op[d][i] = 0; m_spd[d][i] = 0;
      end
    m_phase = 0; m_idx = 0; m_tab_a = 1'b0; m_valid = 1'b0;
  endfunction

  function automatic void model_edge(bit ld, bit st, bit ps, int lv);
    if (m_phase == 1) begin
      for (int d = 0; d < 2; d++) begin
        m_pos[d][m_idx] = (m_idx % 2 == 0) ? 240 : 120;
        m_op[d][m_idx]  = m_tab_a ? 60 : 60 + 10 * (m_idx % 4);
        if (m_tab_a) m_spd[d][m_idx] = (m_idx % 2 == 0) ? -10 : 10;
        else         m_spd[d][m_idx] = (m_idx % 2 == 0) ? -20 : 15;
      end
      m_idx++;
      if (m_idx == N) begin
        m_phase = 2; m_valid = 1'b1;
      end
    end else if (ld) begin
      m_phase = 1; m_idx = 0; m_tab_a = (lv % 2 == 1); m_valid = 1'b0;
    end else if (m_phase == 2 && st && !ps) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++) begin
          int n;
          n = m_pos[d][i] + m_spd[d][i];
          if (d == 0) begin
            if (n < 0)                     m_pos[d][i] = SH - m_op[d][i];
            else if (n > SH - m_op[d][i])  m_pos[d][i] = 0;
            else                           m_pos[d][i] = n;
          end else begin
            if (n < 0) begin
              m_pos[d][i] = 0; m_spd[d][i] = -m_spd[d][i];
            end else if (n + m_op[d][i] > SH) begin
              m_pos[d][i] = SH - m_op[d][i]; m_spd[d][i] = -m_spd[d][i];
            end else begin
              m_pos[d][i] = n;
            end
          end
        end
    end
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pos_w[i*PW +: PW] = PW'(m_pos[0][i]);
      e.op_w[i*PW +: PW]  = PW'(m_op[0][i]);
      e.pos_b[i*PW +: PW] = PW'(m_pos[1][i]);
      e.op_b[i*PW +: PW]  = PW'(m_op[1][i]);
    end
    e.valid = m_valid;
    e.busy  = (m_phase == 1);
    return e;
  endfunction

  // One clock: drive inputs at the falling edge, predict the rising edge.
  task automatic cycle(input bit ld, input bit st, input bit ps, input int lv);
    @(negedge clkenv);
    level_load = ld; step = st; pause = ps; level = PW'(lv);
    if (!rst_n) model_reset();
    else        model_edge(ld, st, ps, lv);
    exp_q.push_back(model_snapshot());
    @(posedge clkenv);
    #2;
  endtask

  // Issue random step/pause cycles until exactly nsteps movement ticks occurred.
  task automatic run_steps(input int nsteps);
    int done;
    bit st, ps;
    done = 0;
    while (done < nsteps) begin
      st = 1'($urandom_range(0, 1));
      ps = ($urandom_range(0, 3) == 0);
      cycle(1'b0, st, ps, 0);
      if (st && !ps) done++;
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_pos_w"}, pos_w, '0);
    chk({tag, "_op_w"},  op_w,  '0);
    chk({tag, "_pos_b"}, pos_b, '0);
    chk({tag, "_op_b"},  op_b,  '0);
    chk({tag, "_valid"}, W'(valid_w | valid_b), '0);
    chk({tag, "_busy"},  W'(busy_w | busy_b),   '0);
  endtask

  // Monitor: after each rising edge compare DUT outputs with the queued prediction.
  always begin
    @(posedge clkenv);
    #1;
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      chk("mon_pos_wrap",   pos_w, e_mon.pos_w);
      chk("mon_op_wrap",    op_w,  e_mon.op_w);
      chk("mon_pos_bounce", pos_b, e_mon.pos_b);
      chk("mon_op_bounce",  op_b,  e_mon.op_b);
      chk("mon_valid", W'({valid_w, valid_b}), W'({e_mon.valid, e_mon.valid}));
      chk("mon_busy",  W'({busy_w, busy_b}),   W'({e_mon.busy, e_mon.busy}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #3;
    chk_all_zero("reset_initial");
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    rst_n = 1'b1;
    // Steps in IDLE are ignored
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 0);

    // Load table A (level 1); pause during LOAD must not stall it
    cycle(1'b1, 1'b0, 1'b0, 1);
    chk("load_busy_edge0", W'(busy_w), W'(1'b1));
    repeat (N) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    chk("load_valid_edge8", W'(valid_w), W'(1'b1));
    chk("load_busy_low",    W'(busy_w),  W'(1'b0));
    chk("bar0_pos", bar(pos_w, 0), W'(240));
    chk("bar0_op",  bar(op_w, 0),  W'(60));
    chk("bar1_pos", bar(pos_w, 1), W'(120));
    chk("bar1_op",  bar(op_w, 1),  W'(60));

    // One step, then a paused step
    cycle(1'b0, 1'b1, 1'b0, 0);
    chk("step1_bar0", bar(pos_w, 0), W'(230));
    chk("step1_bar1", bar(pos_w, 1), W'(130));
    cycle(1'b0, 1'b1, 1'b1, 0);
    chk("paused_bar0", bar(pos_w, 0), W'(230));

    // Wrap: bar0 reaches 0 after 24 steps, wraps to 420 on the 25th
    run_steps(23);
    chk("wrap_bar0_24", bar(pos_w, 0), W'(0));
    run_steps(1);
    chk("wrap_bar0_25", bar(pos_w, 0), W'(420));

    // Bounce: bar1 reaches 420 after 30 steps, clamps then reverses
    run_steps(5);
    chk("bounce_bar1_30", bar(pos_b, 1), W'(420));
    run_steps(1);
    chk("bounce_bar1_31", bar(pos_b, 1), W'(420));
    run_steps(1);
    chk("bounce_bar1_32", bar(pos_b, 1), W'(410));

    // Load and step together: load wins; requests during LOAD are ignored
    cycle(1'b1, 1'b1, 1'b0, 2);
    chk("reload_busy", W'(busy_b), W'(1'b1));
    repeat (N) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    chk("tabB_bar3_op_w", bar(op_w, 3), W'(90));
    chk("tabB_bar3_op_b", bar(op_b, 3), W'(90));
    cycle(1'b0, 1'b1, 1'b0, 0);
    chk("tabB_bar3_spd_w", bar(pos_w, 3), W'(135));
    chk("tabB_bar3_spd_b", bar(pos_b, 3), W'(135));

    // Random running with occasional reloads of random levels
    for (int c = 0; c < 300; c++)
      cycle(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1023)));

    // Reset in the middle of a LOAD, after bar 3 has been written
    while (m_phase == 1) cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 3);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0);
    @(negedge clkenv);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_reset");
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 0);
    chk_all_zero("idle_after_reset");

    // Final load and some movement
    cycle(1'b1, 1'b0, 1'b0, 5);
    repeat (N) cycle(1'b0, 1'b0, 1'b0, 0);
    run_steps(20);

    @(negedge clkenv);
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
